// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter stage of the CPU datapath.
//
// Holds the PC and feeds the external ripple adder (ADD_SRC1/ADD_SRC2).
// The adder's sum (ADD_SUM) comes back as the next PC for increments and
// branches. Also does absolute jumps, and call/return through a small
// internal LIFO return-address stack.
//
// Ports:
//   CLK, RST        clock; synchronous active-high reset
//   EN              advance enable (0 = stall, all state holds)
//   BRANCH/OFFSET   PC-relative branch, two's-complement offset
//   JUMP/TARGET     absolute jump to TARGET
//   CALL            push PC+1, jump to TARGET
//   RET             pop return address into PC
//   ADD_SUM         sum from the external adder
//   ADD_SRC1/2      adder operands (PC, OFFSET-or-1)
//   PC, SP          program counter, stack occupancy
//   FULL/EMPTY/ERR  stack flags; ERR is sticky until RST
module pc_sequencer #(
  parameter int unsigned       WIDTH    = 11,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic                       BRANCH,
  input  logic [WIDTH-1:0]           OFFSET,
  input  logic                       JUMP,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic [WIDTH-1:0]           TARGET,
  input  logic [WIDTH-1:0]           ADD_SUM,
  output logic [WIDTH-1:0]           ADD_SRC1,
  output logic [WIDTH-1:0]           ADD_SRC2,
  output logic [WIDTH-1:0]           PC,
  output logic [$clog2(DEPTH):0]     SP,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ERR
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = AW + 1;

  typedef enum logic [2:0] {
    CMD_INC,
    CMD_BR,
    CMD_JMP,
    CMD_CALL,
    CMD_RET
  } cmd_e;

  logic [WIDTH-1:0]             pc_q, pc_d;
  logic [SPW-1:0]               sp_q, sp_d;
  logic                         err_q, err_d;
  logic [DEPTH-1:0][WIDTH-1:0]  stack_q, stack_d;

  cmd_e                         cmd;
  logic                         full, empty;
  logic [AW-1:0]                push_idx, top_idx;

  // Priority decode. Independent of EN so the adder operands keep
  // tracking the command inputs during a stall.
  always_comb begin
    cmd = CMD_INC;
    if      (RET)    cmd = CMD_RET;
    else if (CALL)   cmd = CMD_CALL;
    else if (JUMP)   cmd = CMD_JMP;
    else if (BRANCH) cmd = CMD_BR;
  end

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  // When full, sp_q[AW-1:0] wraps to 0 so top_idx = DEPTH-1 still points
  // at the newest entry; push_idx is only used when not full.
  assign push_idx = sp_q[AW-1:0];
  assign top_idx  = sp_q[AW-1:0] - AW'(1);

  assign ADD_SRC1 = pc_q;
  assign ADD_SRC2 = (cmd == CMD_BR) ? OFFSET : WIDTH'(1);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (EN) begin
      unique case (cmd)
        CMD_INC, CMD_BR: pc_d = ADD_SUM;
        CMD_JMP:         pc_d = TARGET;
        CMD_CALL: begin
          // Call still jumps on overflow; only the push is dropped.
          pc_d = TARGET;
          if (!full) begin
            stack_d[push_idx] = ADD_SUM;
            sp_d              = sp_q + SPW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RET: begin
          // Underflow degrades to a plain increment.
          if (!empty) begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - SPW'(1);
          end else begin
            pc_d  = ADD_SUM;
            err_d = 1'b1;
          end
        end
        default: pc_d = ADD_SUM;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= RESET_PC;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset term here.
  always_ff @(posedge CLK) begin
    stack_q <= stack_d;
  end

  assign PC    = pc_q;
  assign SP    = sp_q;
  assign FULL  = full;
  assign EMPTY = empty;
  assign ERR   = err_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the CPU datapath: holds the 11-bit PC, drives the operand inputs of the external 11-bit ripple adder, and registers the adder's sum as the next PC. Sequential increment, PC-relative branch, absolute jump, and call/return through a small internal return-address stack. Sits directly upstream of the adder (feeds SRC1/SRC2) and directly downstream of it (consumes its sum).

## Interface
- `WIDTH`, 11: PC and address width; must match the adder width.
- `DEPTH`, 4: return-stack entries; a power of two, 2..8.
- `RESET_PC`, 11'd0: PC value loaded on reset.

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `EN`  in  1  advance enable; 0 = stall, all state holds.
- `BRANCH`  in  1  take PC-relative branch.
- `OFFSET`  in  WIDTH  two's-complement branch offset.
- `JUMP`  in  1  absolute jump to `TARGET`.
- `CALL`  in  1  push return address, jump to `TARGET`.
- `RET`  in  1  pop return address into PC.
- `TARGET`  in  WIDTH  absolute jump/call address.
- `ADD_SUM`  in  WIDTH  sum returned by the external adder.
- `ADD_SRC1`  out  WIDTH  adder operand A; always equals `PC`.
- `ADD_SRC2`  out  WIDTH  adder operand B; `OFFSET` when a branch is selected, else 1.
- `PC`  out  WIDTH  current program counter (register).
- `SP`  out  $clog2(DEPTH)+1  number of valid stack entries.
- `FULL`  out  1  `SP == DEPTH`.
- `EMPTY`  out  1  `SP == 0`.
- `ERR`  out  1  sticky stack overflow/underflow flag.

## Operation
- Command priority when `EN=1`: `RET` > `CALL` > `JUMP` > `BRANCH` > increment. Lower-priority commands asserted in the same cycle are ignored.
- `ADD_SRC1`/`ADD_SRC2` are combinational from `PC` and the selected command. `ADD_SRC2 = OFFSET` only when `BRANCH` is the winning command; otherwise it is 11'd1, so `ADD_SUM` is PC+1 for every non-branch command.
- Increment: `PC <= ADD_SUM`.
- Branch: `PC <= ADD_SUM`, i.e. (PC + OFFSET) mod 2^WIDTH. The carry-out is discarded and wrap-around is legal.
- Jump: `PC <= TARGET`.
- Call:
  - If not `FULL`: push `ADD_SUM` (PC+1), `SP += 1`, `PC <= TARGET`.
  - If `FULL`: no push, `SP` unchanged, `ERR <= 1`, `PC <= TARGET` anyway.
- Ret:
  - If not `EMPTY`: `PC <= stack[SP-1]`, `SP -= 1`.
  - If `EMPTY`: `ERR <= 1`, `SP` unchanged, `PC <= ADD_SUM` (treated as an increment).
- Stack is LIFO storage indexed by `SP`. Entries above `SP` are don't-care and are not cleared on pop.
- `ERR` is cleared only by `RST`.
- Stall (`EN=0`): `PC`, `SP`, stack contents and `ERR` all hold. `ADD_SRC*` still follow the command inputs.
- Reset values: `PC=RESET_PC`, `SP=0`, `EMPTY=1`, `FULL=0`, `ERR=0`. Stack contents are don't-care after reset.

## Timing
- One-cycle latency: a command sampled at edge N is visible on `PC`, `SP` and flags after edge N.
- The adder path (`PC` → `ADD_SRC*` → external adder → `ADD_SUM` → PC register) is single-cycle combinational.
- `FULL`, `EMPTY` and `ERR` are registered or derived directly from registers; they carry no combinational path from command inputs.
- `RST` asserted mid-sequence (stack partially filled, `ERR` set) forces all reset values at the next edge, regardless of `EN` or any command input.
- Back-to-back `CALL`/`RET` on consecutive cycles is supported at full rate with no bubbles.

## Test plan
- Reset then increment: `RST` for 1 cycle, then `EN=1` with no command for 3 cycles → `PC` sequence 0,1,2,3; `ADD_SRC2=1` throughout.
- Branch with wrap: from `PC=0x7FE`, `BRANCH` with `OFFSET=0x003` → `PC=0x001`. Then from `PC=0x010`, `BRANCH` with `OFFSET=0x7FC` (-4) → `PC=0x00C`.
- Call/return nesting: from `PC=0x020`, `CALL` to 0x100, then `CALL` to 0x200, then `RET`, `RET` → `PC` sequence 0x100, 0x200, 0x101, 0x021; `SP` sequence 1, 2, 1, 0; `ERR=0`.
- Overflow/underflow:
  - 5 consecutive `CALL`s with `DEPTH=4` → `FULL=1` after the 4th; the 5th still jumps to `TARGET` and sets `ERR=1`, `SP` stays 4.
  - After reset, `RET` on an empty stack → `PC`=old PC+1, `ERR=1`, `SP=0`.
- Priority and stall:
  - `RET`+`CALL`+`BRANCH` in the same cycle → only the pop occurs.
  - `EN=0` with `JUMP` asserted for 3 cycles → `PC`, `SP` and `ERR` unchanged.
- Reset mid-operation: with `SP=3` and `ERR=1`, assert `RST` together with `CALL` → next cycle `PC=RESET_PC`, `SP=0`, `ERR=0`, `EMPTY=1`.
